// File: rtl/dmem_store_buffer.sv
// Store buffer between the memory-stage data port and a req/ack data memory.
// Stores are posted into a FIFO and drained in the background; loads go straight to memory.
module dmem_store_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wmask,
    input  logic                    cpu_we,
    input  logic                    cpu_re,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    rd_valid,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned MASK_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned WADDR_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH   = PTR_WIDTH + 1;

    typedef struct packed {
        logic [WADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0]  wdata;
        logic [MASK_WIDTH-1:0]  wmask;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    entry_t                r_fifo [DEPTH];
    logic [PTR_WIDTH-1:0]  r_head;
    logic [PTR_WIDTH-1:0]  r_tail;
    logic [CNT_WIDTH-1:0]  r_count;
    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [MASK_WIDTH-1:0] r_mem_wmask;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_rd_valid;

    state_t                w_state_nxt;
    logic                  w_mem_req_nxt;
    logic                  w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
    logic [MASK_WIDTH-1:0] w_mem_wmask_nxt;
    logic [DATA_WIDTH-1:0] w_cpu_rdata_nxt;
    logic                  w_rd_valid_nxt;
    logic                  w_match;
    logic                  w_hit;
    logic                  w_full;
    logic                  w_load;
    logic                  w_enq;
    logic                  w_deq;
    entry_t                w_entry;
    entry_t                w_head_entry;
    logic                  w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^cpu_addr[1:0];

    // Word-address match against every occupied slot, including the one in flight
    always_comb begin
        w_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTR_WIDTH'(PTR_WIDTH'(i) - r_head)} < r_count) &&
                (r_fifo[i].waddr == cpu_addr[ADDR_WIDTH-1:2])) begin
                w_match = 1'b1;
            end
        end
    end

    assign w_hit        = cpu_re && w_match;
    assign w_full       = (r_count == CNT_WIDTH'(DEPTH));
    assign w_load       = cpu_re && !cpu_we;
    assign w_enq        = cpu_we && (cpu_wmask != '0) && !w_full;
    assign w_deq        = (r_state == ST_WR) && mem_ack;
    assign w_entry      = '{waddr: cpu_addr[ADDR_WIDTH-1:2], wdata: cpu_wdata, wmask: cpu_wmask};
    assign w_head_entry = r_fifo[r_head];

    assign stall = (cpu_we && w_full) || (w_load && (w_hit || !r_rd_valid));

    // Memory-port sequencing; loads win over draining when the port is free
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wmask_nxt = r_mem_wmask;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_rd_valid_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load && !w_hit && !r_rd_valid) begin
                    w_state_nxt    = ST_RD;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                end else if (r_count != '0) begin
                    w_state_nxt     = ST_WR;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = {w_head_entry.waddr, 2'b00};
                    w_mem_wdata_nxt = w_head_entry.wdata;
                    w_mem_wmask_nxt = w_head_entry.wmask;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    w_state_nxt   = ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    w_state_nxt     = ST_IDLE;
                    w_mem_req_nxt   = 1'b0;
                    w_cpu_rdata_nxt = mem_rdata;
                    w_rd_valid_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_cpu_rdata <= '0;
            r_rd_valid  <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wmask <= w_mem_wmask_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            if (w_enq) r_tail <= r_tail + PTR_WIDTH'(1);
            if (w_deq) r_head <= r_head + PTR_WIDTH'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_enq) r_fifo[r_tail] <= w_entry;
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
    assign cpu_rdata = r_cpu_rdata;
    assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: transaction-level reference model plus directed
// scenarios and a randomized load/store mix against a variable-latency memory.
`timescale 1ns/1ps
module tb_dmem_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wmask = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        rd_valid;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    dmem_store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .rd_valid(rd_valid), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int          g_lat      = 1;
    bit          g_rand_lat = 1'b0;
    bit          g_hold     = 1'b0;
    int          wait_cnt   = 1;
    logic [31:0] last_rd    = '0;

    function automatic int next_lat();
        return g_rand_lat ? int'($urandom_range(1, 4)) : g_lat;
    endfunction

    // ack arrives in the g_lat-th cycle that mem_req is seen high
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (mem_req && !g_hold) begin
            if (wait_cnt <= 1) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
                if (!mem_we) last_rd = mem_rdata;
                wait_cnt  = next_lat();
            end else begin
                wait_cnt--;
            end
        end else if (!mem_req) begin
            wait_cnt = next_lat();
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } ent_t;

    ent_t        q[$];
    logic        m_req = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wmask = '0;
    logic        m_rdv = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [32:0] req_log[$];
    logic        prev_req = 1'b0;
    bit          hit, full, exp_stall, enq, nxt_rdv;
    ent_t        e;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_req = 1'b0; m_we = 1'b0; m_rdv = 1'b0; m_rdata = '0;
            prev_req = 1'b0;
            chk("rst_mem_req",   64'(mem_req),   64'(0));
            chk("rst_mem_we",    64'(mem_we),    64'(0));
            chk("rst_mem_addr",  64'(mem_addr),  64'(0));
            chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
            chk("rst_mem_wmask", 64'(mem_wmask), 64'(0));
            chk("rst_rd_valid",  64'(rd_valid),  64'(0));
            chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        end else begin
            hit = 1'b0;
            foreach (q[i]) if (q[i].waddr == cpu_addr[31:2]) hit = 1'b1;
            hit       = hit && cpu_re;
            full      = (q.size() == DEPTH);
            exp_stall = (cpu_we && full) || (cpu_re && !cpu_we && (hit || !m_rdv));
            chk("stall",     64'(stall),     64'(exp_stall));
            chk("mem_req",   64'(mem_req),   64'(m_req));
            if (m_req) begin
                chk("mem_we",   64'(mem_we),   64'(m_we));
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                if (m_we) begin
                    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                    chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
                end
            end
            chk("rd_valid",  64'(rd_valid),  64'(m_rdv));
            chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rdata));
            if (mem_req && !prev_req) req_log.push_back({mem_we, mem_addr});
            prev_req = mem_req;

            enq     = cpu_we && (cpu_wmask != 4'h0) && !full;
            nxt_rdv = 1'b0;
            if (m_req) begin
                if (mem_ack) begin
                    m_req = 1'b0;
                    if (m_we) void'(q.pop_front());
                    else begin
                        m_rdata = mem_rdata;
                        nxt_rdv = 1'b1;
                    end
                end
            end else if (cpu_re && !cpu_we && !hit && !m_rdv) begin
                m_req  = 1'b1;
                m_we   = 1'b0;
                m_addr = {cpu_addr[31:2], 2'b00};
            end else if (q.size() != 0) begin
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = {q[0].waddr, 2'b00};
                m_wdata = q[0].wdata;
                m_wmask = q[0].wmask;
            end
            if (enq) begin
                e.waddr = cpu_addr[31:2];
                e.wdata = cpu_wdata;
                e.wmask = cpu_wmask;
                q.push_back(e);
            end
            m_rdv = nxt_rdv;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [32:0] logged(input int i);
        return (req_log.size() > i) ? req_log[i] : 33'h1_FFFF_FFFF;
    endfunction

    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; holds the request while stalled, ends at posedge+1 with inputs idle
    task automatic op(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m, output int stalls);
        drive(we, re, a, d, m);
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        chk("op_stall_timeout", 64'(stall), 64'(0));
        sync();
        idle();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("wait_req_timeout", 64'(mem_req), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!mem_req && !m_req && q.size() == 0) break;
        end
        chk("drain_timeout", 64'(mem_req), 64'(0));
        sync();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    int s;
    int rd_cyc;
    int rel;
    logic [31:0] ra;

    initial begin
        idle();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset in the middle of a held write
        g_hold = 1'b1;
        op(1'b1, 1'b0, 32'h80, 32'hCAFE0080, 4'hF, s);
        wait_req();
        chk("t1_req_before_rst", 64'(mem_req), 64'(1));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t1_req_async_drop", 64'(mem_req), 64'(0));
        chk("t1_we_async_drop",  64'(mem_we),  64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        g_hold = 1'b0;
        req_log.delete();
        op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, s);
        chk("t1_store_no_stall", 64'(s), 64'(0));
        wait_req();
        chk("t1_wr_we",    64'(mem_we),    64'(1));
        chk("t1_wr_addr",  64'(mem_addr),  64'(32'h100));
        chk("t1_wr_mask",  64'(mem_wmask), 64'(4'hF));
        chk("t1_wr_data",  64'(mem_wdata), 64'(32'hDEADBEEF));
        drain();
        chk("t1_old_store_dropped", 64'(req_log.size()), 64'(1));

        // full FIFO: fifth store waits for the first ack
        g_hold = 1'b1;
        req_log.delete();
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b0, 32'h500 + 32'(i * 4), $urandom, 4'hF, s);
            chk("t2_store_accepted", 64'(s), 64'(0));
        end
        fork
            begin
                repeat (3) @(posedge clk);
                g_hold = 1'b0;
            end
        join_none
        op(1'b1, 1'b0, 32'h510, 32'h5555AAAA, 4'hF, s);
        chk("t2_fifth_stalled", 64'(s != 0), 64'(1));
        drain();
        chk("t2_nwrites", 64'(req_log.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            chk("t2_write_order", 64'(logged(i)), 64'({1'b1, 32'h500 + 32'(i * 4)}));

        // load hitting a pending store, memory latency 2
        g_lat = 2;
        req_log.delete();
        op(1'b1, 1'b0, 32'h204, 32'h11223344, 4'h3, s);
        drive(1'b0, 1'b1, 32'h206, 32'h0, 4'h0);
        rd_cyc = -100;
        rel    = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_hit_stall", 64'(stall), 64'(1));
            if (rd_cyc < 0 && mem_req && !mem_we) begin
                rd_cyc = i;
                chk("t3_rd_addr", 64'(mem_addr), 64'(32'h204));
            end
            if (!stall) begin
                rel = i;
                break;
            end
        end
        chk("t3_issue_to_release", 64'(rel - rd_cyc + 1), 64'(3));
        chk("t3_rd_valid", 64'(rd_valid),  64'(1));
        chk("t3_rdata",    64'(cpu_rdata), 64'(last_rd));
        sync();
        idle();
        drain();
        chk("t3_write_first", 64'(logged(0)), 64'({1'b1, 32'h204}));
        chk("t3_read_second", 64'(logged(1)), 64'({1'b0, 32'h204}));

        // load takes the port ahead of two buffered stores
        g_lat = 1;
        g_hold = 1'b1;
        req_log.delete();
        op(1'b1, 1'b0, 32'h600, $urandom, 4'hF, s);
        op(1'b1, 1'b0, 32'h604, $urandom, 4'h1, s);
        op(1'b1, 1'b0, 32'h608, $urandom, 4'h8, s);
        fork
            begin
                repeat (4) @(posedge clk);
                g_hold = 1'b0;
            end
        join_none
        op(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, s);
        chk("t4_load_stalled", 64'(s != 0), 64'(1));
        drain();
        chk("t4_nreq",   64'(req_log.size()), 64'(4));
        chk("t4_req0",   64'(logged(0)), 64'({1'b1, 32'h600}));
        chk("t4_req1",   64'(logged(1)), 64'({1'b0, 32'h300}));
        chk("t4_req2",   64'(logged(2)), 64'({1'b1, 32'h604}));
        chk("t4_req3",   64'(logged(3)), 64'({1'b1, 32'h608}));

        // zero-mask store and store+load together
        req_log.delete();
        op(1'b1, 1'b0, 32'h700, 32'h12345678, 4'h0, s);
        chk("t5_nomask_no_stall", 64'(s), 64'(0));
        repeat (4) sync();
        chk("t5_nomask_no_req", 64'(req_log.size()), 64'(0));
        op(1'b1, 1'b1, 32'h400, 32'h0BADF00D, 4'hF, s);
        chk("t5_both_no_stall", 64'(s), 64'(0));
        drain();
        chk("t5_nreq", 64'(req_log.size()), 64'(1));
        chk("t5_req0", 64'(logged(0)), 64'({1'b1, 32'h400}));

        // randomized mix with variable memory latency
        g_rand_lat = 1'b1;
        for (int n = 0; n < 800; n++) begin
            ra = 32'h800 + 32'($urandom_range(0, 5)) * 32'd4 + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op(1'b1, 1'b0, ra, $urandom, 4'($urandom_range(1, 15)), s);
                4, 5, 6:    op(1'b0, 1'b1, ra, 32'h0, 4'h0, s);
                7:          op(1'b1, 1'b1, ra, $urandom, 4'($urandom_range(0, 15)), s);
                8:          sync();
                default:    op(1'b1, 1'b0, ra, $urandom, 4'h0, s);
            endcase
        end
        drain();
        repeat (2) sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits between the core's memory-stage data port and the data memory, which now has a req/ack handshake with variable latency.
- Absorbs stores into a DEPTH-entry FIFO and drains them to memory in the background.
- Issues loads directly to memory.
- Stalls the core on buffer-full, on a load whose word address matches a pending store, and while a load is outstanding.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width; byte-lane mask width is DATA_WIDTH/8
DEPTH, 4, store FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cpu_addr  input  ADDR_WIDTH  byte address from memory stage
cpu_wdata  input  DATA_WIDTH  store data, already lane-aligned
cpu_wmask  input  DATA_WIDTH/8  store byte-enable
cpu_we  input  1  store request
cpu_re  input  1  load request
cpu_rdata  output  DATA_WIDTH  registered load data, valid when rd_valid=1
stall  output  1  combinational hold request to pipeline
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write, 0 = read; stable while mem_req=1
mem_addr  output  ADDR_WIDTH  request address, word-aligned (low 2 bits forced to 0)
mem_wdata  output  DATA_WIDTH  write data
mem_wmask  output  DATA_WIDTH/8  write byte-enable
mem_ack  input  1  one-cycle completion pulse
mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack on a read

Behaviour:
- Reset (async):
  - FIFO head, tail and count = 0.
  - State = IDLE.
  - mem_req = 0, mem_we = 0; mem_addr, mem_wdata and mem_wmask = 0.
  - cpu_rdata = 0, rd_valid = 0.
  - Reset mid-transaction drops the request immediately and discards all buffered stores; memory must tolerate an abandoned request.
- Request rules:
  - cpu_we=1 with cpu_wmask=0 is a no-op.
  - cpu_we and cpu_re both high: treated as store; cpu_re is ignored.
- hit = cpu_re && some valid entry (including the in-flight head) has addr[ADDR_WIDTH-1:2] == cpu_addr[ADDR_WIDTH-1:2].
- stall = (cpu_we && full) || (cpu_re && !cpu_we && (hit || !rd_valid)).
- Enqueue:
  - Condition: cpu_we && wmask != 0 && !full.
  - Action: write {addr, wdata, wmask} at tail, tail++, count++.
  - When full, no enqueue occurs even if a dequeue completes in the same cycle; the store retries next cycle.
- Dequeue: on mem_ack in state WR, head++ and count--.
- Simultaneous enqueue and dequeue: count is unchanged.
- Pointers wrap modulo DEPTH; full = (count == DEPTH).
- FSM, IDLE:
  - If cpu_re && !cpu_we && !hit && !rd_valid: go to RD; mem_req=1, mem_we=0, mem_addr = word-aligned cpu_addr. Loads have priority over draining.
  - Else if count > 0: go to WR; mem_req=1, mem_we=1, drive the head entry.
  - Else stay in IDLE.
- FSM, WR: hold all outputs until mem_ack; on ack, mem_req=0 and go to IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
- FSM, RD: hold until mem_ack; on ack, cpu_rdata <= mem_rdata, rd_valid <= 1, mem_req=0, go to IDLE.
- rd_valid handshake:
  - rd_valid is high for exactly one cycle, in which stall=0 for the load and the pipeline captures cpu_rdata; it then clears.
  - Load latency from issue cycle to stall release = (memory latency to ack) + 1.
- Load with hit: stall holds while the FIFO drains. The load issues from IDLE in the first cycle no matching entry remains.
- Addresses and data are not checked for alignment; misalignment is the core's responsibility.

Test Plan:
- Reset then store sequence:
  - Stimulus: assert rst mid-WR with mem_req=1, release; then store addr 0x100, data 0xDEADBEEF, mask 0xF.
  - Response: mem_req drops in the reset cycle without waiting for clk; count=0 after release; stall=0 on the store; one cycle later mem_req=1, mem_we=1, mem_addr=0x100, mem_wmask=0xF.
- Full FIFO:
  - Stimulus: 5 consecutive stores with mem_ack withheld.
  - Response: first 4 accepted; stall=1 on the 5th. After the first mem_ack the 5th enqueues one cycle later and drains 5th in order.
- Load hit:
  - Stimulus: store 0x204, mask 0x3, then load 0x206 with ack latency 2.
  - Response: stall held until the 0x204 write acks; read issues with mem_addr=0x204; stall drops 3 cycles after issue with cpu_rdata = mem_rdata.
- Load priority:
  - Stimulus: 2 stores pending, then load 0x300 (no hit) while in IDLE.
  - Response: read issues before both writes; the writes drain afterwards.
- Edge requests:
  - Stimulus: cpu_we=1 with wmask=0; then cpu_we=cpu_re=1 at 0x400.
  - Response: the first causes no enqueue and no stall; the second enqueues one store and issues no read.
